// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encoding and defaults for the fetch sequencer
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        VALID,
        ERR
    } fetch_state_e;

    localparam logic [63:0] FS_RESET_VEC = 64'h0;
    localparam logic [63:0] FS_PC_STEP   = 64'd4;
    localparam int          FS_INSTR_W   = 32;
    localparam int          FS_TIMEOUT   = 255;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing, imem fetch handshake and redirect handling
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_VEC = FS_RESET_VEC,
    parameter logic [63:0] PC_STEP   = FS_PC_STEP,
    parameter int          INSTR_W   = FS_INSTR_W,
    parameter int          TIMEOUT   = FS_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        pc_in,
    output logic [63:0]        nextinst,
    output logic               imem_req,
    output logic [63:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_target,
    output logic               fetch_err
);

    localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    fetch_state_e        state_q, state_d;
    logic                kill_q, kill_d;
    logic [63:0]         kill_tgt_q, kill_tgt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                fetch_err_q, fetch_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            kill_q      <= 1'b0;
            kill_tgt_q  <= '0;
            instr_q     <= '0;
            tcnt_q      <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            kill_tgt_q  <= kill_tgt_d;
            instr_q     <= instr_d;
            tcnt_q      <= tcnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // ProgramCounters has no enable: every state that does not advance must drive pc_in back.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        kill_tgt_d  = kill_tgt_q;
        instr_d     = instr_q;
        tcnt_d      = tcnt_q;
        fetch_err_d = fetch_err_q;
        nextinst    = pc_in;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;

        case (state_q)
            BOOT: begin
                nextinst = RESET_VEC;
                state_d  = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    tcnt_d = '0;
                    if (kill_q || redirect_valid) begin
                        // Stale data: drop it and restart the fetch at the newest target.
                        nextinst = redirect_valid ? redirect_target : kill_tgt_q;
                        kill_d   = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = VALID;
                    end
                end else begin
                    if (redirect_valid) begin
                        kill_d     = 1'b1;
                        kill_tgt_d = redirect_target;
                    end
                    if (tcnt_q == TCNT_LAST) begin
                        fetch_err_d = 1'b1;
                        state_d     = ERR;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                instr       = instr_q;
                if (redirect_valid) begin
                    nextinst = redirect_target;
                    state_d  = FETCH;
                end else if (instr_ready) begin
                    nextinst = pc_in + PC_STEP;
                    state_d  = FETCH;
                end
            end
            default: ;
        endcase
    end

    assign imem_addr = pc_in;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with a transaction-level model
module tb_fetch_sequencer;

    localparam int          IW  = 32;
    localparam int          TMO = 8;
    localparam logic [63:0] RV  = 64'h0;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   pc_in, nextinst, imem_addr, redirect_target;
    logic          imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, fetch_err;
    logic [IW-1:0] imem_rdata, instr;

    int n_chk = 0;
    int n_pass = 0;
    bit const_mem;

    always #5 clk = ~clk;

    // Stand-in for the ProgramCounters register: loads nextinst every edge.
    always @(posedge clk) pc_in <= nextinst;

    fetch_sequencer #(
        .RESET_VEC(RV), .PC_STEP(64'd4), .INSTR_W(IW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .nextinst(nextinst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [IW-1:0] mem_data(input logic [63:0] a);
        if (const_mem) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    // Transaction-level model: where the next instruction must come from and when it may appear.
    logic [63:0] exp_pc;
    bit          dirty, prev_val;
    int          exp_nv = -1;
    int          cyc = 0;
    logic [63:0] deliv_pc[$];
    int          deliv_cyc[$];

    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (reset) begin
            exp_pc = RV; dirty = 0; exp_nv = -1;
        end else begin
            chk("addr_eq_pc", imem_addr, pc_in);
            if (exp_nv >= 0) chk("valid_after_ack", 64'(instr_valid), 64'(exp_nv));
            exp_nv = -1;
            if (fetch_err) begin
                chk("err_req", 64'(imem_req), 64'd0);
                chk("err_valid", 64'(instr_valid), 64'd0);
                chk("err_hold", nextinst, pc_in);
            end else if (instr_valid) begin
                if (!prev_val) begin
                    chk("deliver_pc", pc_in, exp_pc);
                    deliv_pc.push_back(pc_in);
                    deliv_cyc.push_back(cyc);
                end
                chk("instr_data", 64'(instr), 64'(mem_data(pc_in)));
                chk("valid_noreq", 64'(imem_req), 64'd0);
                if (redirect_valid) begin
                    exp_pc = redirect_target;
                    chk("valid_redirect", nextinst, exp_pc);
                end else if (instr_ready) begin
                    exp_pc = pc_in + 64'd4;
                    chk("valid_step", nextinst, exp_pc);
                end else begin
                    chk("valid_hold", nextinst, pc_in);
                end
            end else if (imem_req) begin
                if (imem_ack) begin
                    if (redirect_valid) exp_pc = redirect_target;
                    if (dirty || redirect_valid) begin
                        chk("drop_jump", nextinst, exp_pc);
                        exp_nv = 0;
                    end else begin
                        chk("fetch_pc", pc_in, exp_pc);
                        chk("ack_hold", nextinst, pc_in);
                        exp_nv = 1;
                    end
                    dirty = 0;
                end else begin
                    chk("wait_hold", nextinst, pc_in);
                    if (redirect_valid) begin
                        exp_pc = redirect_target;
                        dirty  = 1;
                    end
                end
            end else begin
                chk("boot_vec", nextinst, RV);
                chk("boot_instr", 64'(instr), 64'd0);
                exp_pc = RV;
            end
        end
        prev_val = instr_valid;
    end

    task automatic drive(input bit a, input bit r, input bit rv, input logic [63:0] t);
        imem_ack        = a & imem_req;
        imem_rdata      = imem_ack ? mem_data(imem_addr) : IW'($urandom);
        instr_ready     = r;
        redirect_valid  = rv;
        redirect_target = t;
    endtask

    task automatic tick(input bit a, input bit r, input bit rv, input logic [63:0] t);
        drive(a, r, rv, t);
        @(negedge clk);
    endtask

    // Entered and left on a falling edge; the ack held high during reset must be ignored.
    task automatic do_reset();
        reset          = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #3;
        chk("rst_nextinst", nextinst, RV);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_err", 64'(fetch_err), 64'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        deliv_pc.delete();
        deliv_cyc.delete();
    endtask

    int          hold, guard, wcnt, dly, n;
    logic [31:0] held;
    bit          a, rv;
    logic [63:0] t;

    initial begin
        reset = 1'b1; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
        redirect_valid = 0; redirect_target = '0; const_mem = 1;
        @(negedge clk);
        do_reset();

        // Zero-wait memory, with a five-cycle decode stall at pc=8.
        tick(1, 1, 0, 0);
        hold = 0; guard = 0; held = '0;
        while (deliv_pc.size() < 4 && guard < 40) begin
            if (instr_valid && pc_in == 64'h8 && hold < 5) begin
                if (hold == 0) held = instr;
                chk("stall_req", 64'(imem_req), 64'd0);
                chk("stall_instr", 64'(instr), 64'(held));
                hold++;
                tick(1, 0, 0, 0);
            end else begin
                tick(1, 1, 0, 0);
            end
            guard++;
        end
        chk("seq_count", 64'(deliv_pc.size()), 64'd4);
        if (deliv_pc.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("seq_pc", deliv_pc[i], 64'(4 * i));
            chk("seq_rate", 64'(deliv_cyc[1] - deliv_cyc[0]), 64'd2);
        end
        chk("stall_len", 64'(hold), 64'd5);

        // Two redirects while the fetch at pc=4 is outstanding: last one wins.
        do_reset();
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("kill_start_pc", pc_in, 64'h4);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 64'h100);
        tick(0, 0, 1, 64'h200);
        tick(1, 0, 0, 0);
        chk("kill_novalid", 64'(instr_valid), 64'd0);
        chk("kill_addr", imem_addr, 64'h200);
        chk("kill_req", 64'(imem_req), 64'd1);
        tick(1, 0, 0, 0);

        // Redirect beats instr_ready in VALID.
        chk("redir_in_valid", 64'(instr_valid), 64'd1);
        drive(0, 1, 1, 64'h40);
        #1 chk("redir_next", nextinst, 64'h40);
        @(negedge clk);
        chk("redir_addr", imem_addr, 64'h40);

        // Sequential step from the top of the address space wraps to zero.
        tick(1, 0, 0, 0);
        tick(0, 0, 1, TOP);
        tick(1, 0, 0, 0);
        chk("wrap_pc", pc_in, TOP);
        drive(0, 1, 0, 0);
        #1 chk("wrap_next", nextinst, 64'h0);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 64'h0);

        // Random traffic: variable ack latency, redirects, decode back-pressure.
        const_mem = 0;
        do_reset();
        wcnt = 0; dly = $urandom_range(0, 3);
        repeat (3000) begin
            a = 0; rv = 0;
            if (imem_req) begin
                if (wcnt >= dly) begin
                    a = 1; wcnt = 0; dly = $urandom_range(0, 3);
                end else wcnt++;
            end
            if (imem_req || instr_valid) rv = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 15) == 0) ? TOP : ({$urandom, $urandom} & ~64'h3);
            tick(a, 1'($urandom_range(0, 1)), rv, t);
        end
        chk("rand_progress", 64'(deliv_pc.size() > 100), 64'd1);

        // Memory never answers: timeout after TMO waiting cycles, then stuck in ERR.
        do_reset();
        tick(0, 0, 0, 0);
        n = 0; guard = 0;
        while (!fetch_err && guard < 50) begin
            if (imem_req) n++;
            tick(0, 0, 0, 0);
            guard++;
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
        chk("tmo_err", 64'(fetch_err), 64'd1);
        chk("tmo_req", 64'(imem_req), 64'd0);
        repeat (5) tick(1, 1, 1, 64'h80);
        chk("err_sticky", 64'(fetch_err), 64'd1);
        chk("err_novalid", 64'(instr_valid), 64'd0);

        // Reset landing mid-fetch drops the request without waiting for a clock edge.
        do_reset();
        chk("err_cleared", 64'(fetch_err), 64'd0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("midfetch_req", 64'(imem_req), 64'd1);
        #1 reset = 1'b1;
        imem_ack = 1'b1;
        #1 chk("async_req_drop", 64'(imem_req), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        tick(1, 1, 0, 0);
        chk("post_rst_novalid", 64'(instr_valid), 64'd0);
        chk("post_rst_req", 64'(imem_req), 64'd1);
        chk("post_rst_pc", pc_in, RV);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
